// File: rtl/spi_sram_responder_pkg.sv
// Shared opcodes and state encoding for the SPI serial-SRAM responder.
// Lets the responder stand in for a 23LC1024-style part on emulation builds.
package spi_sram_responder_pkg;

    localparam logic [7:0] OP_WRMR  = 8'h01;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_RDMR  = 8'h05;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_READ,
        ST_WRITE,
        ST_RDMR,
        ST_WRMR,
        ST_IGNORE
    } state_t;

endpackage

// File: rtl/spi_sram_responder_if.sv
// SPI pin bundle between a bus master (spi_controller or a bench) and the SRAM responder.
interface spi_sram_responder_if;

    logic spi_ss_n;
    logic spi_sck;
    logic spi_mosi;
    logic spi_miso;
    logic spi_miso_oe;

    modport master (output spi_ss_n, spi_sck, spi_mosi, input spi_miso, spi_miso_oe);
    modport slave  (input spi_ss_n, spi_sck, spi_mosi, output spi_miso, spi_miso_oe);

endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, with one-clock rise/fall pulses.
// The chain is deliberately not reset so a pin already low at reset release never looks like a fresh fall.
module spi_sync_edge (
    input  logic clk_i,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [2:0] sync_sr;

    always_ff @(posedge clk_i) begin
        sync_sr <= {sync_sr[1:0], din};
    end

    assign level = sync_sr[1];
    assign rise  = sync_sr[1] & ~sync_sr[2];
    assign fall  = ~sync_sr[1] & sync_sr[2];

endmodule

// File: rtl/spi_sram_responder.sv
// SPI mode-0 slave emulating a sequential-mode serial SRAM on an internal byte array.
// Decodes READ/WRITE/RDMR/WRMR with a 24-bit address, auto-incrementing per byte.
module spi_sram_responder
    import spi_sram_responder_pkg::*;
#(
    parameter int         ADDR_WIDTH = 8,
    parameter logic [7:0] MODE_RESET = 8'h40
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    spi_sram_responder_if.slave  spi,
    output logic                 busy
);

    state_t                  state, state_next;
    logic                    ss_level, ss_rise, ss_fall;
    logic                    sck_level, sck_rise_raw, sck_fall_raw;
    logic                    sck_rise, sck_fall;
    logic [1:0]              mosi_sr;
    logic                    mosi_s;
    logic [4:0]              bit_cnt;
    logic [7:0]              shift_in, tx, mode, byte_in;
    logic [ADDR_WIDTH-1:0]   addr, addr_in, addr_inc;
    logic [ADDR_WIDTH:0]     addr_cat;
    logic                    is_read, miso, mem_we;
    logic [7:0]              mem [0:2**ADDR_WIDTH-1];

    spi_sync_edge u_ss_sync  (.clk_i(clk_i), .din(spi.spi_ss_n), .level(ss_level),
                              .rise(ss_rise), .fall(ss_fall));
    spi_sync_edge u_sck_sync (.clk_i(clk_i), .din(spi.spi_sck),  .level(sck_level),
                              .rise(sck_rise_raw), .fall(sck_fall_raw));

    always_ff @(posedge clk_i) begin
        mosi_sr <= {mosi_sr[0], spi.spi_mosi};
    end

    // sck edges only count while the part is selected
    assign sck_rise = sck_rise_raw & sck_level & ~ss_level;
    assign sck_fall = sck_fall_raw & ~sck_level & ~ss_level;
    assign mosi_s   = mosi_sr[1];
    assign byte_in  = {shift_in[6:0], mosi_s};
    assign addr_cat = {addr, mosi_s};
    assign addr_in  = addr_cat[ADDR_WIDTH-1:0];
    assign addr_inc = addr + ADDR_WIDTH'(1);

    always_comb begin
        state_next = state;
        mem_we     = 1'b0;
        case (state)
            ST_IDLE: if (ss_fall) state_next = ST_CMD;
            ST_CMD: begin
                if (sck_rise && bit_cnt == 5'd7) begin
                    case (byte_in)
                        OP_READ, OP_WRITE: state_next = ST_ADDR;
                        OP_RDMR:           state_next = ST_RDMR;
                        OP_WRMR:           state_next = ST_WRMR;
                        default:           state_next = ST_IGNORE;
                    endcase
                end
            end
            ST_ADDR:  if (sck_rise && bit_cnt == 5'd23) state_next = is_read ? ST_READ : ST_WRITE;
            ST_WRITE: if (sck_rise && bit_cnt == 5'd7) mem_we = 1'b1;
            ST_WRMR:  if (sck_rise && bit_cnt == 5'd7) state_next = ST_IGNORE;
            default: ;
        endcase
        // deselect beats any sck edge in the same clock; a partial byte is dropped
        if (ss_rise) begin
            state_next = ST_IDLE;
            mem_we     = 1'b0;
        end
        if (rst_i) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            mode     <= MODE_RESET;
            miso     <= 1'b0;
            tx       <= '0;
            shift_in <= '0;
            addr     <= '0;
            is_read  <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next == ST_IDLE) begin
                bit_cnt <= '0;
                miso    <= 1'b0;
            end else begin
                case (state)
                    ST_CMD: if (sck_rise) begin
                        shift_in <= byte_in;
                        if (bit_cnt == 5'd7) begin
                            bit_cnt <= '0;
                            is_read <= (byte_in == OP_READ);
                            tx      <= mode;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                    ST_ADDR: if (sck_rise) begin
                        addr <= addr_in;
                        if (bit_cnt == 5'd23) begin
                            bit_cnt <= '0;
                            tx      <= mem[addr_in];
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                    // the last bit of a byte goes out on the same fall that preloads the next byte
                    ST_READ, ST_RDMR: if (sck_fall) begin
                        miso <= tx[7];
                        if (bit_cnt == 5'd7) begin
                            bit_cnt <= '0;
                            if (state == ST_READ) begin
                                addr <= addr_inc;
                                tx   <= mem[addr_inc];
                            end else begin
                                tx   <= mode;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                            tx      <= {tx[6:0], 1'b0};
                        end
                    end
                    ST_WRITE, ST_WRMR: if (sck_rise) begin
                        shift_in <= byte_in;
                        if (bit_cnt == 5'd7) begin
                            bit_cnt <= '0;
                            if (state == ST_WRITE) addr <= addr_inc;
                            else                   mode <= byte_in;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) mem[addr] <= byte_in;
    end

    assign spi.spi_miso    = miso;
    assign spi.spi_miso_oe = (state == ST_READ) || (state == ST_RDMR);
    assign busy            = (state != ST_IDLE);

endmodule
